// File: rtl/fetch_stage.sv
// RV32I instruction fetch stage: owns the PC, keeps one imem request in flight and
// presents the fetched word with its PC in the IF/ID register.
module fetch_stage #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ready,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc
);

    typedef enum logic [1:0] {StReq, StWait, StHold, StDrop} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] buf_inst_q, buf_inst_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic        valid_q, valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] opc_q, opc_d;

    logic        slot_free;
    logic        accept;
    logic        load;
    logic [31:0] load_inst;
    logic [31:0] load_pc;

    assign o_imem_req  = (state_q == StReq) && !i_redirect && !i_rst;
    assign o_imem_addr = pc_q;
    assign accept      = o_imem_req && i_imem_ready;
    assign slot_free   = !valid_q || !i_stall;

    assign o_valid = valid_q;
    assign o_inst  = inst_q;
    assign o_pc    = opc_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        buf_inst_d = buf_inst_q;
        buf_pc_d   = buf_pc_q;
        valid_d    = valid_q;
        inst_d     = inst_q;
        opc_d      = opc_q;
        load       = 1'b0;
        load_inst  = buf_inst_q;
        load_pc    = buf_pc_q;

        if (i_redirect) begin
            pc_d = {i_redirect_pc[31:2], 2'b00};
            unique case (state_q)
                StWait:  state_d = i_imem_rvalid ? StReq : StDrop;
                StDrop:  state_d = StDrop;
                default: state_d = StReq;
            endcase
        end else begin
            unique case (state_q)
                StReq: begin
                    if (accept) begin
                        req_pc_d = pc_q;
                        pc_d     = pc_q + 32'd4;
                        state_d  = StWait;
                    end
                end
                StWait: begin
                    if (i_imem_rvalid) begin
                        if (slot_free) begin
                            load      = 1'b1;
                            load_inst = i_imem_rdata;
                            load_pc   = req_pc_q;
                            state_d   = StReq;
                        end else begin
                            buf_inst_d = i_imem_rdata;
                            buf_pc_d   = req_pc_q;
                            state_d    = StHold;
                        end
                    end
                end
                StHold: begin
                    if (!i_stall) begin
                        load    = 1'b1;
                        state_d = StReq;
                    end
                end
                StDrop: begin
                    if (i_imem_rvalid) state_d = StReq;
                end
                default: state_d = StReq;
            endcase
        end

        // Redirect flushes the slot; otherwise a free slot takes new data or becomes a bubble.
        if (i_redirect || (slot_free && !load)) begin
            valid_d = 1'b0;
            inst_d  = NOP_INST;
            opc_d   = 32'd0;
        end else if (load) begin
            valid_d = 1'b1;
            inst_d  = load_inst;
            opc_d   = load_pc;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= StReq;
            pc_q       <= RESET_ADDR;
            req_pc_q   <= 32'd0;
            buf_inst_q <= NOP_INST;
            buf_pc_q   <= 32'd0;
            valid_q    <= 1'b0;
            inst_q     <= NOP_INST;
            opc_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            buf_inst_q <= buf_inst_d;
            buf_pc_q   <= buf_pc_d;
            valid_q    <= valid_d;
            inst_q     <= inst_d;
            opc_q      <= opc_d;
        end
    end

endmodule
